// File: rtl/tone_pkg.sv
// Shared note/sequence types and note-frequency defaults for the tone generator
// and the tone sequence decoder.
package tone_pkg;

    typedef enum logic [1:0] {
        NOTE_NONE = 2'd0,
        NOTE_LOW  = 2'd1,
        NOTE_MID  = 2'd2,
        NOTE_HIGH = 2'd3
    } note_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ONE,
        S_TWO
    } seq_state_t;

    localparam int unsigned F_LOW_HZ  = 262;
    localparam int unsigned F_MID_HZ  = 349;
    localparam int unsigned F_HIGH_HZ = 491;

    // Nominal period of a tone in clk cycles (truncating).
    function automatic int unsigned period_of(input int unsigned clk_freq,
                                              input int unsigned f);
        return clk_freq / f;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser on an asynchronous input plus a registered rising-edge
// pulse; the pulse appears three clocks after the pin edge.
module sync_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/tone_sequence_decoder.sv
// Measures the period of a square-wave tone, classifies it as LOW/MID/HIGH and
// detects the food (LOW-MID-HIGH) and game-over (HIGH-MID-LOW) jingles.
module tone_sequence_decoder
    import tone_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned F_LOW          = F_LOW_HZ,
    parameter int unsigned F_MID          = F_MID_HZ,
    parameter int unsigned F_HIGH         = F_HIGH_HZ,
    parameter int unsigned TOL_SHIFT      = 5,
    parameter int unsigned MIN_PERIODS    = 4,
    parameter int unsigned SILENCE_CYCLES = 5_000_000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tone_in,
    output logic [1:0] note_code,
    output logic       note_valid,
    output logic       tone_present,
    output logic       food_detected,
    output logic       game_over_detected
);

    // One extra bit so cnt + 1 cannot wrap when cnt is saturated.
    localparam int unsigned PW = CNT_W + 1;
    localparam int unsigned RW = $clog2(MIN_PERIODS + 1);

    localparam logic [PW-1:0]    P_LOW    = PW'(period_of(CLK_FREQ, F_LOW));
    localparam logic [PW-1:0]    P_MID    = PW'(period_of(CLK_FREQ, F_MID));
    localparam logic [PW-1:0]    P_HIGH   = PW'(period_of(CLK_FREQ, F_HIGH));
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] SIL_LAST = CNT_W'(SILENCE_CYCLES - 1);
    localparam logic [RW-1:0]    RUN_MAX  = RW'(MIN_PERIODS);

    function automatic logic in_window(input logic [PW-1:0] p,
                                       input logic [PW-1:0] nom);
        logic [PW-1:0] d;
        d = (p >= nom) ? p - nom : nom - p;
        return d <= (nom >> TOL_SHIFT);
    endfunction

    logic             rise;
    logic             silence;
    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic             primed;
    note_t            cand;
    logic [RW-1:0]    run;
    logic [PW-1:0]    period;
    note_t            meas;
    note_t            nv;
    note_t            first;
    seq_state_t       state;

    sync_edge_det u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (tone_in),
        .rise    (rise)
    );

    always_comb begin
        period  = {1'b0, cnt} + PW'(1);
        meas    = NOTE_NONE;
        accept  = 1'b0;
        if (in_window(period, P_LOW))       meas = NOTE_LOW;
        else if (in_window(period, P_MID))  meas = NOTE_MID;
        else if (in_window(period, P_HIGH)) meas = NOTE_HIGH;
        // A rise landing on the threshold cycle takes priority over silence.
        silence = (cnt == SIL_LAST) && !rise;
        if (meas != NOTE_NONE) begin
            if (meas == cand) accept = (run == RUN_MAX - RW'(1));
            else              accept = (RUN_MAX == RW'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            primed       <= 1'b0;
            cand         <= NOTE_NONE;
            run          <= '0;
            note_code    <= NOTE_NONE;
            note_valid   <= 1'b0;
            tone_present <= 1'b0;
        end else begin
            note_valid <= 1'b0;
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (rise) begin
                cnt          <= '0;
                primed       <= 1'b1;
                tone_present <= 1'b1;
                if (primed) begin
                    if (accept) begin
                        note_valid <= 1'b1;
                        note_code  <= meas;
                    end
                    if (meas == NOTE_NONE) begin
                        cand <= NOTE_NONE;
                        run  <= '0;
                    end else if (meas == cand) begin
                        // Run saturates so a long note pulses only once.
                        if (run != RUN_MAX) run <= run + RW'(1);
                    end else begin
                        cand <= meas;
                        run  <= RW'(1);
                    end
                end
            end else if (silence) begin
                tone_present <= 1'b0;
                primed       <= 1'b0;
                note_code    <= NOTE_NONE;
                cand         <= NOTE_NONE;
                run          <= '0;
            end
        end
    end

    assign nv = note_t'(note_code);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_IDLE;
            first              <= NOTE_NONE;
            food_detected      <= 1'b0;
            game_over_detected <= 1'b0;
        end else begin
            food_detected      <= 1'b0;
            game_over_detected <= 1'b0;
            if (silence) begin
                state <= S_IDLE;
            end else if (note_valid) begin
                case (state)
                    S_IDLE: begin
                        if (nv == NOTE_LOW || nv == NOTE_HIGH) begin
                            first <= nv;
                            state <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (nv == NOTE_MID)       state <= S_TWO;
                        else if (nv != NOTE_NONE) first <= nv;
                    end
                    S_TWO: begin
                        if (first == NOTE_LOW && nv == NOTE_HIGH) begin
                            food_detected <= 1'b1;
                            state         <= S_IDLE;
                        end else if (first == NOTE_HIGH && nv == NOTE_LOW) begin
                            game_over_detected <= 1'b1;
                            state              <= S_IDLE;
                        end else if (nv == NOTE_MID) begin
                            state <= S_IDLE;
                        end else if (nv != NOTE_NONE) begin
                            first <= nv;
                            state <= S_ONE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_sequence_decoder.sv
// Scoreboard bench for tone_sequence_decoder, run at a 50 kHz clock so nominal
// periods are LOW 190, MID 143, HIGH 101 cycles (tolerance 5, 4, 3).
module tb_tone_sequence_decoder;

    localparam int SIL = 600;
    localparam int PL  = 190;
    localparam int PM  = 143;
    localparam int PH  = 101;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tone_in = 1'b0;
    logic [1:0] note_code;
    logic       note_valid, tone_present, food_detected, game_over_detected;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { int kind; int code; int at; } exp_t;
    typedef struct { int idx; int kind; int code; } ev_t;
    exp_t exp_q[$];
    ev_t  bev[$];
    int   bq[$];

    tone_sequence_decoder #(
        .CLK_FREQ       (50_000),
        .SILENCE_CYCLES (SIL)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .tone_in            (tone_in),
        .note_code          (note_code),
        .note_valid         (note_valid),
        .tone_present       (tone_present),
        .food_detected      (food_detected),
        .game_over_detected (game_over_detected)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // kind: 0 note_valid, 1 food_detected, 2 game_over_detected
    task automatic sb_pop(input int kind, input int code);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got kind=%0d code=%0d cyc=%0d, expected no event",
                     kind, code, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.code != code || e.at != cyc) begin
                failures++;
                $display("FAIL sb_event: got kind=%0d code=%0d cyc=%0d expected kind=%0d code=%0d cyc=%0d",
                         kind, code, cyc, e.kind, e.code, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (note_valid)         sb_pop(0, int'(note_code));
            if (food_detected)      sb_pop(1, 0);
            if (game_over_detected) sb_pop(2, 0);
        end
    end

    task automatic add(input int p, input int n);
        repeat (n) bq.push_back(p);
    endtask

    task automatic ev(input int idx, input int kind, input int code);
        ev_t e;
        e.idx = idx; e.kind = kind; e.code = code;
        bev.push_back(e);
    endtask

    // Pin rise at cycle n: rise pulse at n+3, note_valid seen at n+4, jingle pulse at n+5.
    task automatic issue(input int idx);
        exp_t e;
        foreach (bev[k]) begin
            if (bev[k].idx == idx) begin
                e.kind = bev[k].kind;
                e.code = bev[k].code;
                e.at   = cyc + ((bev[k].kind == 0) ? 4 : 5);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic play(input bit close);
        @(negedge clk);
        for (int i = 0; i < bq.size(); i++) begin
            tone_in = 1'b1;
            issue(i);
            repeat (bq[i] / 2) @(negedge clk);
            tone_in = 1'b0;
            repeat (bq[i] - bq[i] / 2) @(negedge clk);
        end
        if (close) begin
            tone_in = 1'b1;
            issue(bq.size());
            repeat (20) @(negedge clk);
            tone_in = 1'b0;
        end
        bq.delete();
        bev.delete();
    endtask

    task automatic levels(input string name, input int tp, input int code);
        check({name, "_present"}, tone_present, tp);
        check({name, "_code"}, note_code, code);
    endtask

    task automatic quiet(input string name);
        repeat (SIL + 100) @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
        levels({name, "_silent"}, 0, 0);
    endtask

    initial begin
        int nom[3] = '{190, 143, 101};
        int tol[3] = '{5, 4, 3};
        int seq[7] = '{1, 3, 2, 3, 1, 2, 3};
        int per[4] = '{0, 190, 143, 101};

        repeat (3) @(negedge clk);
        check("reset_outputs", {note_code, note_valid, tone_present, food_detected, game_over_detected}, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Long LOW tone: one pulse only.
        add(PL, 10); ev(4, 0, 1);
        play(1); levels("low", 1, 1); quiet("low");

        add(PL, 6); add(PM, 6); add(PH, 6);
        ev(4, 0, 1); ev(10, 0, 2); ev(16, 0, 3); ev(16, 1, 0);
        play(1); levels("food", 1, 3); quiet("food");

        add(PH, 6); add(PM, 6); add(PL, 6);
        ev(4, 0, 3); ev(10, 0, 2); ev(16, 0, 1); ev(16, 2, 0);
        play(1); levels("gameover", 1, 1); quiet("gameover");

        for (int n = 0; n < 3; n++) begin
            add(nom[n] + tol[n], 6); ev(4, 0, n + 1);
            play(1); levels("tol_in", 1, n + 1); quiet("tol_in");
            // One out-of-window period must clear the run: 3 + 3 never reaches 4.
            add(nom[n], 3); add(nom[n] + tol[n] + 1, 1); add(nom[n], 3);
            play(1); levels("tol_out", 1, 0); quiet("tol_out");
        end

        add(PL, 6); add(SIL, 1); ev(4, 0, 1);
        play(1); levels("sil_rise_wins", 1, 1); quiet("sil_rise_wins");
        add(PL, 6); add(SIL + 1, 1); ev(4, 0, 1);
        play(1); levels("sil_fires", 1, 0); quiet("sil_fires");

        for (int k = 0; k < 7; k++) begin
            add(per[seq[k]], 6);
            ev(6 * k + 4, 0, seq[k]);
        end
        ev(40, 1, 0);
        play(1); levels("broken", 1, 3); quiet("broken");

        add(PL, 6); ev(4, 0, 1);
        play(1); quiet("gap_low");
        add(PM, 6); add(PH, 6); ev(4, 0, 2); ev(10, 0, 3);
        play(1); levels("gap", 1, 3); quiet("gap");

        add(PL, 6); add(PM, 2); ev(4, 0, 1);
        play(0);
        check("pre_reset_drained", exp_q.size(), 0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_outputs", {note_code, note_valid, tone_present, food_detected, game_over_detected}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        add(PH, 6); ev(4, 0, 3);
        play(1); levels("post_reset", 1, 3); quiet("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tone_sequence_decoder.md
Name: tone_sequence_decoder

Overview:
- Receive-side counterpart of the jingle generator. Samples a square-wave tone line (the speaker signal, or an external microphone comparator), measures its period and classifies it as one of three notes.
- Recognises the food jingle (LOW-MID-HIGH) and the game-over jingle (HIGH-MID-LOW), each as a single-cycle pulse.
- Used for on-board loopback self-test of the sound path and for the game-audio monitor.

Parameters:
- CLK_FREQ, 50_000_000, clk frequency in Hz
- F_LOW, 262, low note Hz
- F_MID, 349, mid note Hz
- F_HIGH, 491, high note Hz
- TOL_SHIFT, 5, match tolerance = P_nom >> TOL_SHIFT (about 3.1 %)
- MIN_PERIODS, 4, consecutive matching periods before a note is accepted
- SILENCE_CYCLES, 5_000_000, clk cycles with no rising edge that count as silence
- CNT_W, 24, period counter width

Ports:
- clk, input, 1, system clock
- reset_n, input, 1, asynchronous active-low reset
- tone_in, input, 1, asynchronous square-wave tone
- note_code, output, 2, last accepted note: 0 NONE, 1 LOW, 2 MID, 3 HIGH
- note_valid, output, 1, one-cycle pulse when a note is accepted
- tone_present, output, 1, level; 1 while rising edges arrive within SILENCE_CYCLES of each other
- food_detected, output, 1, one-cycle pulse on LOW-MID-HIGH
- game_over_detected, output, 1, one-cycle pulse on HIGH-MID-LOW

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs 0; note_code = NONE.
  - Counters 0, primed = 0, sequence FSM = S_IDLE, synchroniser flops 0.
- Input conditioning:
  - 2-FF synchroniser on tone_in, then rising-edge detect.
  - rise asserts 3 clk after a pin edge.
- Period measurement:
  - cnt increments every cycle and saturates at 2^CNT_W-1.
  - On rise: if primed, period = cnt + 1; then cnt <= 0 and primed <= 1.
  - The first edge after reset or after silence only primes; it produces no measurement.
- Classification:
  - P_nom = CLK_FREQ / F_x (integer): 190839, 143266, 101832.
  - A period matches note x if |period − P_nom| ≤ P_nom >> TOL_SHIFT.
  - No match gives UNKNOWN. The windows are disjoint by construction.
- Note acceptance:
  - Track the candidate note and a run counter.
  - Match equal to the candidate: run++.
  - Different match: candidate = new note, run = 1.
  - UNKNOWN: candidate = NONE, run = 0.
  - When run reaches MIN_PERIODS: note_valid pulses the next cycle and note_code updates that same cycle.
  - At most one pulse per run; further matching periods do not re-pulse.
- Silence:
  - Triggered when cnt reaches SILENCE_CYCLES − 1 without a rise.
  - Effects: tone_present <= 0, primed <= 0, note_code <= NONE, run = 0, FSM to S_IDLE.
  - A rise in the same cycle as the silence threshold wins: no silence.
  - tone_present <= 1 on the first rise after silence.
- Sequence FSM (advances only on note_valid):
  - S_IDLE:
    - LOW or HIGH: store first, go to S_ONE.
    - MID: stay.
  - S_ONE:
    - MID: go to S_TWO.
    - LOW or HIGH: store as new first, stay in S_ONE.
  - S_TWO:
    - first=LOW and note=HIGH: food_detected pulse.
    - first=HIGH and note=LOW: game_over_detected pulse.
    - Either match, or MID: go to S_IDLE.
    - Any other LOW or HIGH: store as new first, go to S_ONE.
  - Detection pulse is registered 1 cycle after the third note_valid.
- Reset mid-operation: immediate return to reset state; any partial jingle is discarded.

Decomposition:
- tone_pkg:
  - note_t enum {NOTE_NONE, NOTE_LOW, NOTE_MID, NOTE_HIGH}
  - seq_state_t enum {S_IDLE, S_ONE, S_TWO}
  - default note frequency constants, shared with the generator
  - function period_of(clk_freq, f)
- Sub-module sync_edge_det (2-FF synchroniser plus rising-edge pulse); reusable for button and encoder inputs.

Test Plan:
- LOW note: 262 Hz square (190840-cycle period) for 3_000_000 cycles. Expect exactly one note_valid with note_code=1, arriving 1 cycle after the 5th rise; tone_present=1.
- Food jingle: 3_000_000 cycles each of 262, 349, 491 Hz, then tone_in held low. Expect:
  - note_valid three times, with codes 1, 2, 3
  - food_detected one pulse, 1 cycle after the third note_valid
  - game_over_detected never
  - tone_present=0 and note_code=0, SILENCE_CYCLES after the last edge
- Game-over jingle: 491, 349, 262 Hz. Expect game_over_detected one pulse and food_detected never.
- Tolerance edges:
  - period 190839 + 5963: accepted as LOW
  - period 190839 + 5964: UNKNOWN, run cleared, no note_valid
  - Repeat the check for the MID and HIGH windows.
- Broken sequence LOW, HIGH, MID, HIGH: no pulses until the run completes. Then LOW, MID, HIGH yields exactly one food_detected; a silence inserted between LOW and MID returns the FSM to S_IDLE, and the sequence yields no pulse.
- Assert reset_n mid-MID-note of the food jingle, then resume with HIGH. Expect all outputs 0 during reset and no food_detected afterwards.
